// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional divider datapath enabled by defining MULDIV_DIV_EN.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   p_q, p_d;
    logic [XLEN-1:0]     mb_q, mb_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                byp_q, byp_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     ma, mb;
    logic                byp;
    logic [XLEN-1:0]     byp_val;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     mul_val;
    logic [XLEN-1:0]     div_val;
    logic [XLEN-1:0]     fin_val;

`ifdef MULDIV_DIV_EN
    logic                rneg_q, rneg_d;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       shl, diff;
    logic [2*XLEN-1:0]   div_step;
    logic [XLEN-1:0]     quo, rem;
`endif

    // Operand decode for the accept cycle
    always_comb begin
        a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn = op[2] ? ~op[0] : ~op[1];
        a_neg = a_sgn & a[XLEN-1];
        b_neg = b_sgn & b[XLEN-1];
        ma    = a_neg ? -a : a;
        mb    = b_neg ? -b : b;
`ifdef MULDIV_DIV_EN
        div_zero = (b == '0);
        div_ovf  = ~op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        byp      = op[2] & (div_zero | div_ovf);
        byp_val  = '0;
        if (div_zero) begin
            byp_val = op[1] ? a : '1;
        end else if (div_ovf) begin
            byp_val = op[1] ? '0 : a;
        end
`else
        byp     = op[2];
        byp_val = '0;
`endif
    end

    // One iteration of each datapath
    always_comb begin
        mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]}
                 + {1'b0, (p_q[0] ? mb_q : {XLEN{1'b0}})};
        mul_step = {mul_sum, p_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        shl  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        diff = shl - {1'b0, mb_q};
        if (!diff[XLEN]) begin
            div_step = {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        end else begin
            div_step = {shl[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end
`endif
    end

    // Sign correction and output selection
    always_comb begin
        prod_s  = neg_q ? -p_q : p_q;
        mul_val = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                       : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        quo     = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
        rem     = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
        div_val = op_q[1] ? rem : quo;
`else
        div_val = '0;
`endif
        fin_val = byp_q ? p_q[XLEN-1:0] : (op_q[2] ? div_val : mul_val);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        mb_d     = mb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        byp_d    = byp_q;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rneg_d   = rneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    mb_d  = mb;
                    neg_d = a_neg ^ b_neg;
                    cnt_d = '0;
                    byp_d = byp;
`ifdef MULDIV_DIV_EN
                    rneg_d = a_neg;
`endif
                    if (byp) begin
                        p_d     = {{XLEN{1'b0}}, byp_val};
                        state_d = FIN;
                    end else begin
                        p_d     = {{XLEN{1'b0}}, ma};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
`ifdef MULDIV_DIV_EN
                p_d = op_q[2] ? div_step : mul_step;
`else
                p_d = mul_step;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d   = 1'b1;
                result_d = fin_val;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush kills everything in flight, including a FIN-cycle result
        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            mb_q     <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            byp_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            mb_q     <= mb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            byp_q    <= byp_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rneg_q <= 1'b0;
        end else begin
            rneg_q <= rneg_d;
        end
    end
`endif

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
